// File: rtl/key_event_decoder.sv
`default_nettype none
// ============================================================================
// Module      : key_event_decoder
// Description : Turns a debounced active-low key level into gesture events:
//               single/multi-click sequences (with click count) and long
//               presses with auto-repeat pulses while the key stays held.
//               Event outputs are registered one-cycle pulses.
// Ports       : clk         - system clock
//               rst         - asynchronous active-high reset
//               key_n_db    - debounced key level, 0 = pressed (clk domain)
//               click_valid - pulse: click sequence ended
//               click_num   - click count, non-zero only with click_valid
//               long_pulse  - pulse: hold reached LONG_CNT cycles
//               rpt_pulse   - pulse every REPEAT_CNT cycles while long-held
//               busy        - high in every state except IDLE
// Revision    : 1.0 - initial release
// ============================================================================
module key_event_decoder #(
    parameter logic [23:0] LONG_CNT   = 24'd12_000_000,
    parameter logic [23:0] GAP_CNT    = 24'd3_600_000,
    parameter logic [23:0] REPEAT_CNT = 24'd2_400_000,
    parameter logic [2:0]  MAX_CLICKS = 3'd7
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_n_db,
    output logic       click_valid,
    output logic [2:0] click_num,
    output logic       long_pulse,
    output logic       rpt_pulse,
    output logic       busy
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_PRESSED   = 2'd1,
        ST_GAP       = 2'd2,
        ST_LONG_HELD = 2'd3
    } state_t;

    localparam logic [23:0] c_LONG_LAST = LONG_CNT - 24'd1;
    localparam logic [23:0] c_GAP_LAST  = GAP_CNT - 24'd1;
    localparam logic [23:0] c_RPT_LAST  = REPEAT_CNT - 24'd1;

    state_t      r_state;
    logic [23:0] r_timer;
    logic [2:0]  r_clicks;
    logic        r_key;

    logic w_press;
    logic w_release;

    // r_key resets to "released", so a key already held when reset lifts is
    // seen as a fresh press on the first clock.
    assign w_press   = r_key & ~key_n_db;
    assign w_release = ~r_key & key_n_db;

    assign busy = (r_state != ST_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_timer     <= 24'd0;
            r_clicks    <= 3'd0;
            r_key       <= 1'b1;
            click_valid <= 1'b0;
            click_num   <= 3'd0;
            long_pulse  <= 1'b0;
            rpt_pulse   <= 1'b0;
        end else begin
            r_key       <= key_n_db;
            click_valid <= 1'b0;
            click_num   <= 3'd0;
            long_pulse  <= 1'b0;
            rpt_pulse   <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    // Timer is unobservable here; holding it at zero keeps it
                    // from ever wrapping during long idle periods.
                    r_timer <= 24'd0;
                    if (w_press) begin
                        r_state  <= ST_PRESSED;
                        r_clicks <= 3'd1;
                    end
                end

                ST_PRESSED: begin
                    // Release wins over the long limit on the same clock.
                    if (w_release) begin
                        r_state <= ST_GAP;
                        r_timer <= 24'd0;
                    end else if (r_timer == c_LONG_LAST) begin
                        r_state    <= ST_LONG_HELD;
                        r_timer    <= 24'd0;
                        r_clicks   <= 3'd0;
                        long_pulse <= 1'b1;
                    end else begin
                        r_timer <= r_timer + 24'd1;
                    end
                end

                ST_GAP: begin
                    // Press wins over the gap limit on the same clock.
                    if (w_press) begin
                        r_state  <= ST_PRESSED;
                        r_timer  <= 24'd0;
                        r_clicks <= (r_clicks >= MAX_CLICKS) ? MAX_CLICKS
                                                             : r_clicks + 3'd1;
                    end else if (r_timer == c_GAP_LAST) begin
                        r_state     <= ST_IDLE;
                        r_timer     <= 24'd0;
                        r_clicks    <= 3'd0;
                        click_valid <= 1'b1;
                        click_num   <= r_clicks;
                    end else begin
                        r_timer <= r_timer + 24'd1;
                    end
                end

                ST_LONG_HELD: begin
                    if (w_release) begin
                        r_state <= ST_IDLE;
                        r_timer <= 24'd0;
                    end else if (r_timer == c_RPT_LAST) begin
                        r_timer   <= 24'd0;
                        rpt_pulse <= 1'b1;
                    end else begin
                        r_timer <= r_timer + 24'd1;
                    end
                end

                default: begin
                    r_state  <= ST_IDLE;
                    r_timer  <= 24'd0;
                    r_clicks <= 3'd0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_key_event_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_key_event_decoder
// Description : Directed self-checking bench for key_event_decoder with short
//               timing constants (LONG=100, GAP=40, REPEAT=20, MAX_CLICKS=3).
//               Output pulses are logged with the clock-edge index that
//               produced them and compared against hand-derived expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_key_event_decoder;

    logic       clk = 1'b0;
    logic       rst;
    logic       key_n_db;
    logic       click_valid;
    logic [2:0] click_num;
    logic       long_pulse;
    logic       rpt_pulse;
    logic       busy;

    key_event_decoder #(
        .LONG_CNT   (24'd100),
        .GAP_CNT    (24'd40),
        .REPEAT_CNT (24'd20),
        .MAX_CLICKS (3'd3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .key_n_db    (key_n_db),
        .click_valid (click_valid),
        .click_num   (click_num),
        .long_pulse  (long_pulse),
        .rpt_pulse   (rpt_pulse),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Edge index: the value cyc takes just after posedge number k is k.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_err  = 0;
    int n_viol = 0;

    // Event log: kind 0 = click, 1 = long, 2 = repeat.
    int ev_kind[$];
    int ev_cyc[$];
    int ev_num[$];

    logic p_cv = 1'b0, p_lp = 1'b0, p_rp = 1'b0;

    always @(negedge clk) begin
        if (click_valid) begin ev_kind.push_back(0); ev_cyc.push_back(cyc); ev_num.push_back(int'(click_num)); end
        if (long_pulse)  begin ev_kind.push_back(1); ev_cyc.push_back(cyc); ev_num.push_back(int'(click_num)); end
        if (rpt_pulse)   begin ev_kind.push_back(2); ev_cyc.push_back(cyc); ev_num.push_back(int'(click_num)); end
        if (int'(click_valid) + int'(long_pulse) + int'(rpt_pulse) > 1) n_viol++;
        if ((click_valid && p_cv) || (long_pulse && p_lp) || (rpt_pulse && p_rp)) n_viol++;
        if (!click_valid && click_num != 3'd0) n_viol++;
        p_cv = click_valid;
        p_lp = long_pulse;
        p_rp = rpt_pulse;
    end

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic chk_ev(input string tag, input int i, input int kind, input int c, input int num);
        if (i >= ev_kind.size()) begin
            check({tag, "_present"}, ev_kind.size(), i + 1);
        end else begin
            check({tag, "_kind"}, ev_kind[i], kind);
            check({tag, "_cyc"},  ev_cyc[i],  c);
            check({tag, "_num"},  ev_num[i],  num);
        end
    endtask

    task automatic clear_ev();
        ev_kind.delete();
        ev_cyc.delete();
        ev_num.delete();
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Hold the key low for 'low' sampling clocks; p = press-sampling edge,
    // r = release-sampling edge.
    task automatic press_release(input int low, output int p, output int r);
        key_n_db = 1'b0;
        p = cyc + 1;
        tick(low);
        key_n_db = 1'b1;
        r = cyc + 1;
    endtask

    // 'g' idle clocks between the release-sampling and next press-sampling edge.
    task automatic gap(input int g);
        tick(g + 1);
    endtask

    int p, r, r1, r2;

    initial begin
        rst      = 1'b1;
        key_n_db = 1'b1;
        tick(3);
        check("rst_busy",  int'(busy), 0);
        check("rst_cv",    int'(click_valid), 0);
        check("rst_num",   int'(click_num), 0);
        check("rst_long",  int'(long_pulse), 0);
        check("rst_rpt",   int'(rpt_pulse), 0);
        rst = 1'b0;
        tick(5);

        // Single click
        clear_ev();
        press_release(10, p, r);
        tick(60);
        check("single_count", ev_kind.size(), 1);
        chk_ev("single", 0, 0, r + 40, 1);

        // Double click
        clear_ev();
        press_release(10, p, r1);
        gap(15);
        press_release(10, p, r2);
        tick(60);
        check("double_count", ev_kind.size(), 1);
        chk_ev("double", 0, 0, r2 + 40, 2);

        // Five clicks, gap 39: next press lands on the gap-limit clock and
        // wins, so the sequence continues and the count saturates at 3.
        clear_ev();
        for (int i = 0; i < 5; i++) begin
            press_release(10, p, r);
            if (i < 4) gap(39);
        end
        tick(60);
        check("sat_count", ev_kind.size(), 1);
        chk_ev("sat", 0, 0, r + 40, 3);

        // Gap 40: sequence closes before the next press
        clear_ev();
        press_release(10, p, r1);
        gap(40);
        press_release(10, p, r2);
        tick(60);
        check("split_count", ev_kind.size(), 2);
        chk_ev("split0", 0, 0, r1 + 40, 1);
        chk_ev("split1", 1, 0, r2 + 40, 1);

        // Long press with repeats
        clear_ev();
        press_release(165, p, r);
        check("long_busy_held", int'(busy), 1);
        tick(1);
        check("long_busy_after", int'(busy), 0);
        tick(60);
        check("long_count", ev_kind.size(), 4);
        chk_ev("long", 0, 1, p + 100, 0);
        chk_ev("rpt0", 1, 2, p + 120, 0);
        chk_ev("rpt1", 2, 2, p + 140, 0);
        chk_ev("rpt2", 3, 2, p + 160, 0);

        // Release on the clock that the long limit would trigger
        clear_ev();
        press_release(100, p, r);
        tick(60);
        check("prio_count", ev_kind.size(), 1);
        chk_ev("prio", 0, 0, r + 40, 1);

        // Asynchronous reset mid-GAP with two clicks pending
        clear_ev();
        press_release(10, p, r);
        gap(15);
        press_release(10, p, r);
        tick(10);
        check("pre_rst_busy", int'(busy), 1);
        #3;
        rst = 1'b1;
        #1;
        check("arst_busy", int'(busy), 0);
        check("arst_cv",   int'(click_valid), 0);
        check("arst_num",  int'(click_num), 0);
        key_n_db = 1'b0;
        tick(3);
        rst = 1'b0;
        tick(1);
        check("arst_held_press", int'(busy), 1);
        tick(9);
        key_n_db = 1'b1;
        r = cyc + 1;
        tick(60);
        check("arst_count", ev_kind.size(), 1);
        chk_ev("arst", 0, 0, r + 40, 1);

        check("pulse_rules", n_viol, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/key_event_decoder.md
Name: key_event_decoder

Overview:
- Sits directly downstream of the button debouncer and consumes its debounced active-low key level.
- Classifies each key gesture into one of two kinds:
  - single/multi-click: a count of presses separated by short gaps.
  - long press: with auto-repeat pulses while the key stays held.
- Outputs are single-cycle event pulses for the application FSMs (menus, counters, LED modes).
- Default timing constants assume a 12 MHz system clock.

Parameters:
- LONG_CNT, 24'd12_000_000: hold cycles before a press counts as long (1 s).
- GAP_CNT, 24'd3_600_000: release cycles that close a click sequence (300 ms).
- REPEAT_CNT, 24'd2_400_000: repeat interval while long-held (200 ms).
- MAX_CLICKS, 3'd7: saturation value of the click count (1..7).

Ports:
- clk, input, 1: system clock.
- rst, input, 1: reset. One clock; reset is asynchronous and active-high.
- key_n_db, input, 1: debounced key level, 0 = pressed. Synchronous to clk.
- click_valid, output, 1: one-cycle pulse; the click sequence has ended.
- click_num, output, 3: number of clicks. Valid only while click_valid = 1, otherwise 0.
- long_pulse, output, 1: one-cycle pulse when a hold reaches LONG_CNT.
- rpt_pulse, output, 1: one-cycle pulse every REPEAT_CNT cycles while long-held.
- busy, output, 1: high in every state except IDLE.

Behaviour:
- Edge detection:
  - key_r samples key_n_db every clk; key_r resets to 1.
  - press = key_r & ~key_n_db; release = ~key_r & key_n_db.
  - A key already held when rst deasserts is seen as a press on the first clock.
- Reset: state = IDLE, timer = 0, clicks = 0, key_r = 1, and all outputs = 0. Reset mid-sequence discards pending clicks and emits nothing.
- timer: 24-bit. Cleared on every state transition, otherwise increments by 1 per clk. Never wraps, because each state exits at its limit.
- FSM states: IDLE, PRESSED, GAP, LONG_HELD.
  - IDLE:
    - On press: go to PRESSED, clicks = 1.
  - PRESSED:
    - On release: go to GAP. Release has priority over the long limit on the same clock.
    - Else, when timer == LONG_CNT-1: go to LONG_HELD, set long_pulse for the next cycle, clicks = 0. Clicks pending from this sequence are discarded.
  - GAP:
    - On press: go to PRESSED, clicks = min(clicks+1, MAX_CLICKS). Press has priority over the gap limit on the same clock.
    - Else, when timer == GAP_CNT-1: go to IDLE, set click_valid = 1 and click_num = clicks for the next cycle, then clicks = 0.
  - LONG_HELD:
    - On release: go to IDLE. No click and no pulse.
    - Else, when timer == REPEAT_CNT-1: set rpt_pulse for the next cycle, timer = 0, stay in LONG_HELD.
- Latency:
  - All outputs are registered.
  - click_valid rises exactly GAP_CNT clocks after the clock that sampled the final release.
  - long_pulse rises LONG_CNT clocks after the press-sampling clock.
  - The first rpt_pulse follows long_pulse by REPEAT_CNT clocks.
- Pulse width: every pulse lasts exactly one cycle. At most one of click_valid, long_pulse and rpt_pulse is high in any cycle.
- click_num saturates at MAX_CLICKS. Further presses extend the sequence but do not increment the count.
- Parameter legality:
  - All count parameters must be ≥ 2.
  - MAX_CLICKS must be in 1..7.
  - Illegal values are unsupported.

Test Plan (overrides: LONG_CNT=100, GAP_CNT=40, REPEAT_CNT=20, MAX_CLICKS=3):
- Single click: hold key_n_db low 10 cycles, then release. click_valid pulses once with click_num=1, 40 cycles after release. No long_pulse.
- Double click: low 10, high 15, low 10, release. Exactly one click_valid with click_num=2, 40 cycles after the second release.
- Saturation and gap boundary: five clicks with gaps of 39 cycles. One click_valid with click_num=3. Then repeat with a 40-cycle gap: two separate events.
- Long press: hold low 165 cycles. long_pulse at cycle 100, rpt_pulse at cycles 120, 140 and 160. No click_valid after release. busy drops the cycle after release.
- Boundary priority: release sampled on the same clock that timer hits LONG_CNT-1. No long_pulse; click_valid with click_num=1 follows.
- Async reset: assert rst mid-GAP with 2 clicks pending. Outputs are 0 immediately and no click_valid ever appears. Key held low at deassert: treated as a new press.
